grf_wb_queue: RTL

//  Write-back side of the GRF write port. Buffers register-write requests from the datapath (WB stage).

---
 rtl/grf_wb_queue_pkg.sv | 8 +
 rtl/wb_lookup.sv | 45 ++++
 rtl/grf_wb_queue.sv | 160 ++++++++++++++++
 3 files changed

// File: rtl/grf_wb_queue_pkg.sv
// Shared constants for the GRF write-back path.
// Widths match the GRF: 5-bit register numbers, 32-bit data and PC.
package grf_wb_queue_pkg;
    localparam int GRF_AW       = 5;
    localparam int GRF_DW       = 32;
    localparam int PC_W         = 32;
    localparam int WB_DEPTH_DEF = 4;
endpackage

// File: rtl/wb_lookup.sv
// Forwarding lookup over pending GRF writes.
// Visits the output register first, then queue entries oldest to youngest, so the youngest match wins.
module wb_lookup
    import grf_wb_queue_pkg::*;
#(
    parameter int DEPTH = WB_DEPTH_DEF,
    parameter int PW    = $clog2(DEPTH)
) (
    input  logic [DEPTH-1:0]             valid_i,
    input  logic [DEPTH-1:0][GRF_AW-1:0] addr_i,
    input  logic [DEPTH-1:0][GRF_DW-1:0] data_i,
    input  logic [PW-1:0]                head_i,
    input  logic                         out_valid_i,
    input  logic [GRF_AW-1:0]            out_addr_i,
    input  logic [GRF_DW-1:0]            out_data_i,
    input  logic [GRF_AW-1:0]            lk_addr_i,
    output logic                         hit_o,
    output logic [GRF_DW-1:0]            data_o
);

    logic [PW-1:0] idx_s;

    // Priority match: each later (younger) candidate overrides earlier ones.
    always_comb begin
        hit_o  = 1'b0;
        data_o = '0;
        idx_s  = head_i;
        if (out_valid_i && (out_addr_i == lk_addr_i) && (lk_addr_i != 5'd0)) begin
            hit_o  = 1'b1;
            data_o = out_data_i;
        end else begin
            hit_o  = 1'b0;
        end
        for (int i = 0; i < DEPTH; i++) begin
            idx_s = head_i + i[PW-1:0];
            if (valid_i[idx_s] && (addr_i[idx_s] == lk_addr_i) && (lk_addr_i != 5'd0)) begin
                hit_o  = 1'b1;
                data_o = data_i[idx_s];
            end else begin
                data_o = data_o;
            end
        end
    end

endmodule

// File: rtl/grf_wb_queue.sv
// In-order write-back queue feeding the GRF write port, with two forwarding lookups.
// Define WB_TRACE_EN to print a simulation trace line for every GRF write.
module grf_wb_queue
    import grf_wb_queue_pkg::*;
#(
    parameter int DEPTH = WB_DEPTH_DEF
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [GRF_AW-1:0]          in_wa,
    input  logic [GRF_DW-1:0]          in_wd,
    input  logic [PC_W-1:0]            in_pc,
    input  logic                       drain_en,
    output logic                       RegWrite,
    output logic [GRF_AW-1:0]          WA,
    output logic [GRF_DW-1:0]          WD,
    output logic [PC_W-1:0]            PC,
    input  logic [GRF_AW-1:0]          lk_a1,
    output logic                       lk_hit1,
    output logic [GRF_DW-1:0]          lk_d1,
    input  logic [GRF_AW-1:0]          lk_a2,
    output logic                       lk_hit2,
    output logic [GRF_DW-1:0]          lk_d2,
    output logic [$clog2(DEPTH):0]     count
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [PW-1:0]                  wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]                  count_q, count_d;
    logic [DEPTH-1:0]               valid_q, valid_d;
    logic [DEPTH-1:0][GRF_AW-1:0]   addr_q, addr_d;
    logic [DEPTH-1:0][GRF_DW-1:0]   data_q, data_d;
    logic [DEPTH-1:0][PC_W-1:0]     pc_q, pc_d;
    logic                           regwrite_q, regwrite_d;
    logic [GRF_AW-1:0]              wa_q, wa_d;
    logic [GRF_DW-1:0]              wd_q, wd_d;
    logic [PC_W-1:0]                pco_q, pco_d;
    logic                           full_s, accept_s, push_s, pop_s;

    assign full_s   = (count_q == CW'(DEPTH));
    assign in_ready = !full_s;
    assign accept_s = in_valid && !full_s;
    // Writes to $0 complete the handshake but are dropped here.
    assign push_s   = accept_s && (in_wa != 5'd0);
    assign pop_s    = drain_en && (count_q != '0);

    // Next-state: pop head into the output stage, push the new request at the tail.
    always_comb begin
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        valid_d    = valid_q;
        addr_d     = addr_q;
        data_d     = data_q;
        pc_d       = pc_q;
        regwrite_d = 1'b0;
        wa_d       = wa_q;
        wd_d       = wd_q;
        pco_d      = pco_q;
        if (pop_s) begin
            regwrite_d        = 1'b1;
            wa_d              = addr_q[rd_ptr_q];
            wd_d              = data_q[rd_ptr_q];
            pco_d             = pc_q[rd_ptr_q];
            valid_d[rd_ptr_q] = 1'b0;
            rd_ptr_d          = rd_ptr_q + PW'(1);
        end else begin
            regwrite_d = 1'b0;
        end
        if (push_s) begin
            valid_d[wr_ptr_q] = 1'b1;
            addr_d[wr_ptr_q]  = in_wa;
            data_d[wr_ptr_q]  = in_wd;
            pc_d[wr_ptr_q]    = in_pc;
            wr_ptr_d          = wr_ptr_q + PW'(1);
        end else begin
            wr_ptr_d = wr_ptr_q;
        end
        case ({push_s, pop_s})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    // State registers; reset discards queued and in-flight writes at once.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            valid_q    <= '0;
            addr_q     <= '0;
            data_q     <= '0;
            pc_q       <= '0;
            regwrite_q <= 1'b0;
            wa_q       <= '0;
            wd_q       <= '0;
            pco_q      <= '0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            valid_q    <= valid_d;
            addr_q     <= addr_d;
            data_q     <= data_d;
            pc_q       <= pc_d;
            regwrite_q <= regwrite_d;
            wa_q       <= wa_d;
            wd_q       <= wd_d;
            pco_q      <= pco_d;
        end
    end

    assign RegWrite = regwrite_q;
    assign WA       = wa_q;
    assign WD       = wd_q;
    assign PC       = pco_q;
    assign count    = count_q;

    wb_lookup #(.DEPTH(DEPTH), .PW(PW)) u_lk1 (
        .valid_i     (valid_q),
        .addr_i      (addr_q),
        .data_i      (data_q),
        .head_i      (rd_ptr_q),
        .out_valid_i (regwrite_q),
        .out_addr_i  (wa_q),
        .out_data_i  (wd_q),
        .lk_addr_i   (lk_a1),
        .hit_o       (lk_hit1),
        .data_o      (lk_d1)
    );

    wb_lookup #(.DEPTH(DEPTH), .PW(PW)) u_lk2 (
        .valid_i     (valid_q),
        .addr_i      (addr_q),
        .data_i      (data_q),
        .head_i      (rd_ptr_q),
        .out_valid_i (regwrite_q),
        .out_addr_i  (wa_q),
        .out_data_i  (wd_q),
        .lk_addr_i   (lk_a2),
        .hit_o       (lk_hit2),
        .data_o      (lk_d2)
    );

`ifdef WB_TRACE_EN
    // Trace each write as the GRF commits it.
    always @(posedge clk) begin
        if (regwrite_q) begin
            $display("@%h: $%d <= %h", pco_q, wa_q, wd_q);
        end
    end
`endif

endmodule
